data_memory_slave: RTL and testbench
====================================

Name: data_memory_slave

Overview:
- Downstream memory responder for the core's LSU data port.
- Consumes req/we/addr/be/wdata and returns gnt, rvalid and rdata using the OBI-style split address and response phases.
- Provides a word-addressed RAM with byte-enable writes, a fixed read/response latency and a bounded number of outstanding transactions.
- Serves as the DUT-side memory in the regfile/LSU UVM environment and as a synthesizable reference responder.

Parameters:
- DEPTH, 1024: number of 32-bit words; must be a power of 2 and ≥ 4.
- RD_LATENCY, 2: cycles from address acceptance to rvalid; range 1..8.
- MAX_OUTSTANDING, 2: maximum number of accepted transactions without a response; range 1..RD_LATENCY.
- LFSR_SEED, 32'hACE1_0001: non-zero seed for the optional stall LFSR.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_req_i  in  1  LSU request valid.
- data_we_i  in  1  1 = write, 0 = read.
- data_addr_i  in  32  byte address.
- data_be_i  in  4  byte enables; bit k selects wdata[8k+7:8k].
- data_wdata_i  in  32  write data.
- data_gnt_o  out  1  address-phase grant; combinational from the request and internal state.
- data_rvalid_o  out  1  response valid, one cycle per accepted transaction.
- data_rdata_o  out  32  read data, valid only when data_rvalid_o=1 on a read response.

Behaviour:
- Reset (rst_n low, asynchronous):
  - data_gnt_o=0, data_rvalid_o=0, data_rdata_o=0.
  - Outstanding count=0; response pipeline cleared; LFSR loaded with LFSR_SEED.
  - RAM contents are not reset; they persist across reset.
- Word index = data_addr_i[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4. addr[1:0] is ignored (no misalignment error).
- Grant: data_gnt_o = data_req_i && (outstanding < MAX_OUTSTANDING || data_rvalid_o). A response retiring this cycle frees its slot for a same-cycle grant.
- Acceptance: data_req_i && data_gnt_o at the rising edge ending cycle t.
- Write accepted in cycle t:
  - RAM bytes with be=1 are updated at that edge; bytes with be=0 are unchanged.
  - be=4'b0000 is accepted and still responded to, but modifies nothing.
- Read accepted in cycle t:
  - RAM is sampled at acceptance. A write accepted in cycle t is visible to a read accepted in cycle t+1 or later, not to one in cycle t (only one request per cycle, so no conflict).
  - Full 32-bit word returned regardless of be.
- Response:
  - data_rvalid_o=1 in exactly cycle t+RD_LATENCY, for exactly one cycle, with responses in order.
  - data_rdata_o = read word for read responses, 32'h0 for write responses and whenever rvalid=0.
  - Implemented as a RD_LATENCY-deep shift pipeline of {valid, we, data}.
- Outstanding counter:
  - +1 on acceptance, −1 on rvalid, unchanged when both occur.
  - Never exceeds MAX_OUTSTANDING.
  - With MAX_OUTSTANDING=RD_LATENCY, one accept per cycle is sustainable indefinitely.
- Request stability: the master holds req/we/addr/be/wdata until gnt. The slave requires nothing beyond this. A dropped request before gnt is legal and simply not accepted.
- Reset mid-operation: in-flight responses are discarded (no rvalid after reset release). Writes already accepted remain committed.
- No rready exists; the LSU must always accept rvalid.

Optional Feature:
- Macro: DATA_MEM_RANDOM_GNT_STALL_EN.
- Defined:
  - A 32-bit Galois LFSR (taps 32,22,2,1) advances every cycle out of reset.
  - data_gnt_o additionally requires LFSR bit 0 = 1, giving pseudo-random address-phase backpressure.
  - Response latency is unchanged.
- Undefined: no LFSR is instantiated and the grant follows the base rule only.

Test Plan:
- Reset: hold rst_n=0 with req=1 -> gnt=0, rvalid=0, rdata=0. Release -> first read accepted in cycle t, rvalid in cycle t+2 (defaults).
- Byte-enable merge: write 0x0000_0010 data 0xDEAD_BEEF be=4'hF, then write the same address 0x1122_3344 be=4'b0101, then read -> rdata=0xDE22_BE44 two cycles after read acceptance; write responses carry rdata=0.
- Back-to-back: reads to 0x0, 0x4, 0x8, 0xC in consecutive cycles (MAX_OUTSTANDING=2) -> gnt high every cycle, rvalid high 4 consecutive cycles in order, outstanding ≤ 2.
- Backpressure: MAX_OUTSTANDING=1, RD_LATENCY=3, continuous req -> gnt in cycles 0, 3, 6; rvalid in cycles 3, 6, 9.
- Wrap and reset mid-flight: write 0xCAFE_F00D at 0x0000_1000 (DEPTH=1024), read 0x0000_0000 -> 0xCAFE_F00D. Accept a read, assert rst_n=0 next cycle -> no rvalid after release; the write is still readable.
- Stall (DATA_MEM_RANDOM_GNT_STALL_EN defined, seed 32'hACE1_0001): 100 cycles continuous req -> gnt only when LFSR[0]=1, matching the reference-model sequence exactly; every accepted request gets rvalid after exactly RD_LATENCY cycles.

Source files
------------

// File: rtl/data_memory_slave.sv
// data_memory_slave: OBI-style LSU data memory with byte-enable writes, fixed response latency and bounded outstanding requests; define DATA_MEM_RANDOM_GNT_STALL_EN for LFSR grant stalls
module data_memory_slave #(
  parameter int DEPTH = 1024,
  parameter int RD_LATENCY = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] mem [DEPTH];
  logic [RD_LATENCY-1:0] pipe_v, pipe_w;
  logic [31:0] pipe_d [RD_LATENCY];
  logic [3:0] outstanding;
  logic [AW-1:0] idx;
  logic accept, stall_ok;
  logic unused_addr;
  assign idx = data_addr_i[AW+1:2];
  assign unused_addr = ^{data_addr_i[31:AW+2], data_addr_i[1:0]};
`ifdef DATA_MEM_RANDOM_GNT_STALL_EN
  logic [31:0] lfsr;
  // Galois LFSR for taps 32,22,2,1, free-running out of reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr <= LFSR_SEED;
    else lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
  assign stall_ok = lfsr[0];
`else
  assign stall_ok = 1'b1;
`endif
  assign data_gnt_o = rst_n && data_req_i && stall_ok &&
                      (outstanding < 4'(MAX_OUTSTANDING) || data_rvalid_o);
  assign accept = data_req_i && data_gnt_o;
  assign data_rvalid_o = pipe_v[RD_LATENCY-1];
  assign data_rdata_o = (data_rvalid_o && !pipe_w[RD_LATENCY-1]) ? pipe_d[RD_LATENCY-1] : 32'h0;
  // RAM is never reset; only granted writes touch the enabled bytes
  always_ff @(posedge clk)
    if (accept && data_we_i)
      for (int i = 0; i < 4; i++)
        if (data_be_i[i]) mem[idx][8*i+:8] <= data_wdata_i[8*i+:8];
  // response shift pipeline, read word captured at acceptance
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pipe_v <= '0;
      pipe_w <= '0;
      for (int k = 0; k < RD_LATENCY; k++) pipe_d[k] <= 32'h0;
    end else begin
      pipe_v[0] <= accept;
      pipe_w[0] <= data_we_i;
      pipe_d[0] <= (accept && !data_we_i) ? mem[idx] : 32'h0;
      for (int k = 1; k < RD_LATENCY; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        pipe_w[k] <= pipe_w[k-1];
        pipe_d[k] <= pipe_d[k-1];
      end
    end
  // in-flight count; a retiring response and a new accept cancel out
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) outstanding <= 4'd0;
    else if (accept && !data_rvalid_o) outstanding <= outstanding + 4'd1;
    else if (!accept && data_rvalid_o) outstanding <= outstanding - 4'd1;
endmodule

// File: tb/tb_data_memory_slave.sv
// tb_data_memory_slave: directed checks of the data memory responder (default and MAX_OUTSTANDING=1/RD_LATENCY=3 instances)
module tb_data_memory_slave;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic req_a, we_a, gnt_a, rv_a;
  logic [31:0] addr_a, wdata_a, rd_a;
  logic [3:0] be_a;
  logic req_b, we_b, gnt_b, rv_b;
  logic [31:0] addr_b, wdata_b, rd_b;
  logic [3:0] be_b;
  int errors = 0;
  int checks = 0;
  logic [31:0] vals [4] = '{32'hCAFE_F00D, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};

  data_memory_slave dut_a (
    .clk(clk), .rst_n(rst_n), .data_req_i(req_a), .data_we_i(we_a), .data_addr_i(addr_a),
    .data_be_i(be_a), .data_wdata_i(wdata_a), .data_gnt_o(gnt_a), .data_rvalid_o(rv_a), .data_rdata_o(rd_a)
  );
  data_memory_slave #(.RD_LATENCY(3), .MAX_OUTSTANDING(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_req_i(req_b), .data_we_i(we_b), .data_addr_i(addr_b),
    .data_be_i(be_b), .data_wdata_i(wdata_b), .data_gnt_o(gnt_b), .data_rvalid_o(rv_b), .data_rdata_o(rd_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    @(posedge clk);
    #1;
    req_a = r; we_a = w; addr_a = a; be_a = b; wdata_a = d;
    @(negedge clk);
  endtask

  task automatic cycb(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    req_b = r; we_b = w; addr_b = a; be_b = 4'hF; wdata_b = d;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = 1'b1; we_a = 1'b0; addr_a = 32'h0; be_a = 4'hF; wdata_a = 32'h0;
    req_b = 1'b0; we_b = 1'b0; addr_b = 32'h0; be_b = 4'hF; wdata_b = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", {31'b0, gnt_a}, 32'd0);
    chk("rst_rvalid", {31'b0, rv_a}, 32'd0);
    chk("rst_rdata", rd_a, 32'h0);
`ifdef DATA_MEM_RANDOM_GNT_STALL_EN
    begin
      logic [31:0] m;
      logic [2:0] acc;
      m = 32'hACE1_0001;
      acc = 3'b000;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      req_a = 1'b1; we_a = 1'b1; addr_a = 32'h0; wdata_a = 32'h0;
      @(negedge clk);
      for (int c = 0; c < 100; c++) begin
        if (c > 0) cyc(1'b1, 1'b1, 32'(4 * c), 4'hF, 32'(c));
        chk("stall_gnt", {31'b0, gnt_a}, {31'b0, m[0]});
        chk("stall_rvalid", {31'b0, rv_a}, {31'b0, acc[1]});
        acc = {acc[1:0], m[0]};
        m = {1'b0, m[31:1]} ^ (m[0] ? 32'h8020_0003 : 32'h0);
      end
    end
`else
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_a = 1'b1; we_a = 1'b1; addr_a = 32'h10; be_a = 4'hF; wdata_a = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("wr1_gnt", {31'b0, gnt_a}, 32'd1);
    chk("wr1_rvalid", {31'b0, rv_a}, 32'd0);
    cyc(1'b1, 1'b1, 32'h10, 4'b0101, 32'h1122_3344);
    chk("wr2_gnt", {31'b0, gnt_a}, 32'd1);
    chk("wr2_rvalid", {31'b0, rv_a}, 32'd0);
    cyc(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    chk("rd_gnt", {31'b0, gnt_a}, 32'd1);
    chk("wr1_resp_valid", {31'b0, rv_a}, 32'd1);
    chk("wr1_resp_data", rd_a, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 4'hF, 32'h0);
    chk("wr2_resp_valid", {31'b0, rv_a}, 32'd1);
    chk("wr2_resp_data", rd_a, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 4'hF, 32'h0);
    chk("merge_valid", {31'b0, rv_a}, 32'd1);
    chk("merge_data", rd_a, 32'hDE22_BE44);
    cyc(1'b0, 1'b0, 32'h0, 4'hF, 32'h0);
    chk("idle_rvalid", {31'b0, rv_a}, 32'd0);
    chk("idle_rdata", rd_a, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, (i == 0) ? 32'h1000 : 32'(4 * i), 4'hF, vals[i]);
      chk("b2b_wr_gnt", {31'b0, gnt_a}, 32'd1);
      chk("b2b_wr_rvalid", {31'b0, rv_a}, (i >= 2) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 32'(4 * i), 4'hF, 32'h0);
      chk("b2b_rd_gnt", {31'b0, gnt_a}, 32'd1);
      chk("b2b_rd_rvalid", {31'b0, rv_a}, 32'd1);
      chk("b2b_rd_rdata", rd_a, (i < 2) ? 32'h0 : vals[i-2]);
    end
    for (int i = 2; i < 4; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 4'hF, 32'h0);
      chk("b2b_tail_rvalid", {31'b0, rv_a}, 32'd1);
      chk("b2b_tail_rdata", rd_a, vals[i]);
    end
    cyc(1'b0, 1'b0, 32'h0, 4'hF, 32'h0);
    chk("b2b_drain", {31'b0, rv_a}, 32'd0);
    cyc(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    chk("mid_gnt", {31'b0, gnt_a}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_a = 1'b0;
    @(negedge clk);
    chk("mid_rst_rvalid", {31'b0, rv_a}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_rvalid", {31'b0, rv_a}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 4'hF, 32'h0);
      chk("mid_flush_rvalid", {31'b0, rv_a}, 32'd0);
    end
    cyc(1'b1, 1'b0, 32'h1000, 4'hF, 32'h0);
    chk("wrap_gnt", {31'b0, gnt_a}, 32'd1);
    cyc(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    chk("persist_gnt", {31'b0, gnt_a}, 32'd1);
    cyc(1'b0, 1'b0, 32'h0, 4'hF, 32'h0);
    chk("wrap_rvalid", {31'b0, rv_a}, 32'd1);
    chk("wrap_rdata", rd_a, 32'hCAFE_F00D);
    cyc(1'b0, 1'b0, 32'h0, 4'hF, 32'h0);
    chk("persist_rvalid", {31'b0, rv_a}, 32'd1);
    chk("persist_rdata", rd_a, 32'hDE22_BE44);
    for (int c = 0; c < 10; c++) begin
      cycb(1'b1, 1'b1, 32'h40, 32'(c));
      chk("bp_gnt", {31'b0, gnt_b}, (c % 3 == 0) ? 32'd1 : 32'd0);
      chk("bp_rvalid", {31'b0, rv_b}, (c >= 3 && c % 3 == 0) ? 32'd1 : 32'd0);
      chk("bp_rdata", rd_b, 32'h0);
    end
    cycb(1'b0, 1'b0, 32'h0, 32'h0);
    chk("bp_idle_rvalid", {31'b0, rv_b}, 32'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
